// File: rtl/init_pkg.sv
// Shared types and default timing constants for the irrigation init sequencer.
package init_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHK_LVL = 3'd1,
    S_PRIME   = 3'd2,
    S_PRESS   = 3'd3,
    S_DONE    = 3'd4,
    S_FAULT   = 3'd5
  } init_state_t;

  localparam int PRIME_CYC_DEF = 4;
  localparam int LEVEL_TO_DEF  = 6;
  localparam int PRESS_TO_DEF  = 8;
  localparam int RETRY_MAX_DEF = 2;

endpackage

// File: rtl/init_timer.sv
// Loadable down-counter that parks at zero; expire flags the last cycle of a window.
module init_timer #(
  parameter int W = 4
) (
  input  logic         Ck,
  input  logic         Clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge Ck) begin
    if (Clr)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/init_fsm.sv
// Irrigation init sequencer: level check, pump prime, pressurize with retry.
// state     | meaning
// IDLE      | waiting for schedule enable H1
// CHK_LVL   | waiting for reservoir level OK, bounded by LEVEL_TO
// PRIME     | pump on for PRIME_CYC cycles
// PRESS     | pump on, valve open, waiting for line pressure, bounded by PRESS_TO
// DONE      | ready, O6 low releases the operation stage
// FAULT     | sticky alarm until operator acknowledge I3
module init_fsm
  import init_pkg::*;
#(
  parameter int PRIME_CYC = PRIME_CYC_DEF,
  parameter int LEVEL_TO  = LEVEL_TO_DEF,
  parameter int PRESS_TO  = PRESS_TO_DEF,
  parameter int RETRY_MAX = RETRY_MAX_DEF
) (
  input  logic Ck,
  input  logic Clr,
  input  logic H1,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  output logic O1,
  output logic O2,
  output logic O4,
  output logic O5,
  output logic O6
);

  localparam int TMAX_A = (PRIME_CYC > LEVEL_TO) ? PRIME_CYC : LEVEL_TO;
  localparam int TMAX   = (TMAX_A > PRESS_TO) ? TMAX_A : PRESS_TO;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int RW     = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

  init_state_t   state, nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [TW-1:0] ld_val;
  logic          expire;
  logic          load;

  always_ff @(posedge Ck) begin
    if (Clr) begin
      state <= S_IDLE;
      retry <= '0;
    end else begin
      state <= nxt;
      retry <= retry_nxt;
    end
  end

  always_comb begin
    nxt       = state;
    retry_nxt = retry;
    // Losing the schedule enable outranks every success or timeout.
    if (state != S_IDLE && state != S_FAULT && !H1) begin
      nxt       = S_IDLE;
      retry_nxt = '0;
    end else begin
      case (state)
        S_IDLE:    if (H1) nxt = S_CHK_LVL;
        S_CHK_LVL: begin
          if (I1)          nxt = S_PRIME;
          else if (expire) nxt = S_FAULT;
        end
        S_PRIME:   if (expire) nxt = S_PRESS;
        S_PRESS: begin
          if (I2) begin
            nxt = S_DONE;
          end else if (expire) begin
            if (retry < RMAX) begin
              nxt       = S_PRIME;
              retry_nxt = retry + 1'b1;
            end else begin
              nxt = S_FAULT;
            end
          end
        end
        S_DONE:    nxt = S_DONE;
        S_FAULT: begin
          if (I3) begin
            nxt       = S_IDLE;
            retry_nxt = '0;
          end
        end
        default:   nxt = S_IDLE;
      endcase
    end
  end

  // Timer reloads on every state entry; states without a window park it at zero.
  always_comb begin
    ld_val = '0;
    case (nxt)
      S_CHK_LVL: ld_val = TW'(LEVEL_TO);
      S_PRIME:   ld_val = TW'(PRIME_CYC);
      S_PRESS:   ld_val = TW'(PRESS_TO);
      default:   ld_val = '0;
    endcase
  end

  assign load = (nxt != state);

  init_timer #(.W(TW)) u_timer (
    .Ck       (Ck),
    .Clr      (Clr),
    .load     (load),
    .load_val (ld_val),
    .expire   (expire)
  );

  always_comb begin
    O1 = 1'b0;
    O2 = 1'b0;
    O4 = 1'b0;
    O5 = 1'b0;
    O6 = 1'b1;
    case (state)
      S_PRIME: O1 = 1'b1;
      S_PRESS: begin
        O1 = 1'b1;
        O2 = 1'b1;
      end
      S_DONE: begin
        O5 = 1'b1;
        O6 = 1'b0;
      end
      S_FAULT: O4 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_init_fsm.sv
// Scenario bench for init_fsm: per-cycle stimulus plans with a queue of expected outputs.
module tb_init_fsm;
  import init_pkg::*;

  // expected output vectors {O1,O2,O4,O5,O6}
  localparam logic [4:0] IDL = 5'b00001;
  localparam logic [4:0] CHK = 5'b00001;
  localparam logic [4:0] PRI = 5'b10001;
  localparam logic [4:0] PRS = 5'b11001;
  localparam logic [4:0] DON = 5'b00010;
  localparam logic [4:0] FLT = 5'b00101;

  logic Ck = 1'b0;
  logic Clr, H1, I1, I2, I3;
  logic O1, O2, O4, O5, O6;

  int checks = 0;
  int errors = 0;

  logic [9:0] plan_q[$];
  logic [4:0] exp_q[$];

  init_fsm #(
    .PRIME_CYC (PRIME_CYC_DEF),
    .LEVEL_TO  (LEVEL_TO_DEF),
    .PRESS_TO  (PRESS_TO_DEF),
    .RETRY_MAX (RETRY_MAX_DEF)
  ) dut (
    .Ck (Ck), .Clr (Clr), .H1 (H1), .I1 (I1), .I2 (I2), .I3 (I3),
    .O1 (O1), .O2 (O2), .O4 (O4), .O5 (O5), .O6 (O6)
  );

  always #5 Ck = ~Ck;

  // stim = {H1,I1,I2,I3,Clr}; n cycles of the same inputs and expected outputs after each edge
  task automatic seg(input logic [4:0] stim, input logic [4:0] exp, input int n);
    for (int i = 0; i < n; i++) plan_q.push_back({stim, exp});
  endtask

  task automatic test_reset();
    logic [9:0] pl;
    logic [4:0] ex, got;
    int k = 0;
    seg(5'b11111, IDL, 2);
    seg(5'b00000, IDL, 1);
    while (plan_q.size() > 0) begin
      pl = plan_q.pop_front();
      {H1, I1, I2, I3, Clr} = pl[9:5];
      exp_q.push_back(pl[4:0]);
      @(posedge Ck); #1;
      got = {O1, O2, O4, O5, O6};
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL reset cyc%0d outs=%b expected=%b", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_happy_path();
    logic [9:0] pl;
    logic [4:0] ex, got;
    int k = 0;
    seg(5'b00001, IDL, 2);
    seg(5'b11000, CHK, 1);
    seg(5'b11000, PRI, 1);
    seg(5'b10100, PRI, 3);
    seg(5'b10100, PRS, 1);
    seg(5'b10100, DON, 1);
    seg(5'b10000, DON, 2);
    seg(5'b00000, IDL, 1);
    while (plan_q.size() > 0) begin
      pl = plan_q.pop_front();
      {H1, I1, I2, I3, Clr} = pl[9:5];
      exp_q.push_back(pl[4:0]);
      @(posedge Ck); #1;
      got = {O1, O2, O4, O5, O6};
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL happy_path cyc%0d outs=%b expected=%b", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_level_timeout();
    logic [9:0] pl;
    logic [4:0] ex, got;
    int k = 0;
    seg(5'b00001, IDL, 1);
    seg(5'b10000, CHK, 6);
    seg(5'b10000, FLT, 1);
    seg(5'b00000, FLT, 2);
    seg(5'b11100, FLT, 1);
    seg(5'b00010, IDL, 1);
    seg(5'b00000, IDL, 1);
    // level OK arriving on the timeout edge still wins
    seg(5'b10000, CHK, 6);
    seg(5'b11000, PRI, 1);
    seg(5'b00000, IDL, 1);
    while (plan_q.size() > 0) begin
      pl = plan_q.pop_front();
      {H1, I1, I2, I3, Clr} = pl[9:5];
      exp_q.push_back(pl[4:0]);
      @(posedge Ck); #1;
      got = {O1, O2, O4, O5, O6};
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL level_timeout cyc%0d outs=%b expected=%b", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_retry_success();
    logic [9:0] pl;
    logic [4:0] ex, got;
    int k = 0;
    seg(5'b00001, IDL, 1);
    seg(5'b11000, CHK, 1);
    seg(5'b11000, PRI, 4);
    seg(5'b10000, PRS, 8);
    seg(5'b10000, PRI, 4);
    seg(5'b10000, PRS, 8);
    seg(5'b10000, PRI, 4);
    seg(5'b10000, PRS, 8);
    seg(5'b10100, DON, 1);
    seg(5'b00000, IDL, 1);
    while (plan_q.size() > 0) begin
      pl = plan_q.pop_front();
      {H1, I1, I2, I3, Clr} = pl[9:5];
      exp_q.push_back(pl[4:0]);
      @(posedge Ck); #1;
      got = {O1, O2, O4, O5, O6};
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL retry_success cyc%0d outs=%b expected=%b", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_retry_exhaust();
    logic [9:0] pl;
    logic [4:0] ex, got;
    int k = 0;
    seg(5'b00001, IDL, 1);
    seg(5'b11000, CHK, 1);
    seg(5'b11000, PRI, 4);
    seg(5'b10000, PRS, 8);
    seg(5'b10000, PRI, 4);
    seg(5'b10000, PRS, 8);
    seg(5'b10000, PRI, 4);
    seg(5'b10000, PRS, 8);
    seg(5'b10000, FLT, 3);
    seg(5'b00010, IDL, 1);
    while (plan_q.size() > 0) begin
      pl = plan_q.pop_front();
      {H1, I1, I2, I3, Clr} = pl[9:5];
      exp_q.push_back(pl[4:0]);
      @(posedge Ck); #1;
      got = {O1, O2, O4, O5, O6};
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL retry_exhaust cyc%0d outs=%b expected=%b", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_abort();
    logic [9:0] pl;
    logic [4:0] ex, got;
    int k = 0;
    seg(5'b00001, IDL, 1);
    seg(5'b11000, CHK, 1);
    seg(5'b11000, PRI, 4);
    seg(5'b10000, PRS, 8);
    seg(5'b10000, PRI, 4);
    seg(5'b10000, PRS, 8);
    seg(5'b10000, PRI, 2);
    seg(5'b00000, IDL, 1);
    // restart: one timed-out window must retry, proving the counter cleared
    seg(5'b11000, CHK, 1);
    seg(5'b11000, PRI, 4);
    seg(5'b10000, PRS, 8);
    seg(5'b10000, PRI, 1);
    seg(5'b01100, IDL, 1);
    // abort coincides with level OK
    seg(5'b10000, CHK, 1);
    seg(5'b01000, IDL, 1);
    while (plan_q.size() > 0) begin
      pl = plan_q.pop_front();
      {H1, I1, I2, I3, Clr} = pl[9:5];
      exp_q.push_back(pl[4:0]);
      @(posedge Ck); #1;
      got = {O1, O2, O4, O5, O6};
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL abort cyc%0d outs=%b expected=%b", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_press();
    logic [9:0] pl;
    logic [4:0] ex, got;
    int k = 0;
    seg(5'b00001, IDL, 1);
    seg(5'b11000, CHK, 1);
    seg(5'b11000, PRI, 4);
    seg(5'b10000, PRS, 3);
    seg(5'b11101, IDL, 1);
    seg(5'b00000, IDL, 1);
    // fault acknowledge together with reset
    seg(5'b10000, CHK, 6);
    seg(5'b10000, FLT, 1);
    seg(5'b00011, IDL, 1);
    while (plan_q.size() > 0) begin
      pl = plan_q.pop_front();
      {H1, I1, I2, I3, Clr} = pl[9:5];
      exp_q.push_back(pl[4:0]);
      @(posedge Ck); #1;
      got = {O1, O2, O4, O5, O6};
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL reset_mid_press cyc%0d outs=%b expected=%b", k, got, ex);
      end
      k++;
    end
  endtask

  initial begin
    Clr = 1'b1; H1 = 1'b0; I1 = 1'b0; I2 = 1'b0; I3 = 1'b0;
    test_reset();
    test_happy_path();
    test_level_timeout();
    test_retry_success();
    test_retry_exhaust();
    test_abort();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
